// File: rtl/xif_coproc_pkg.sv
// xif_coproc_pkg: shared constants, entry states and table-entry layout for the XIF coprocessor
package xif_coproc_pkg;
    localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
    localparam logic [6:0] FUNCT7_OP = 7'h00;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_MIN} alu_op_e;
    typedef enum logic [1:0] {EMPTY, ISSUED, COMMITTED, KILLED} entry_state_e;
    typedef struct packed {
        entry_state_e state;
        logic [4:0]   rd;
        logic [31:0]  data;
    } entry_t;
endpackage

// File: rtl/xif_coproc_alu.sv
// xif_coproc_alu: combinational add/sub/xor/signed-min on two 32-bit operands
// ports: op selects the operation, a/b operands, y result (wraps modulo 2^32)
module xif_coproc_alu
    import xif_coproc_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_XOR ? a ^ b :
               ($signed(a) < $signed(b)) ? a : b;
endmodule

// File: rtl/xif_coproc_responder.sv
// xif_coproc_responder: XIF coprocessor keeping an in-order table of offloaded ALU results
// ports: clk_i/rst_i clock and sync reset; issue_* offload handshake and response;
//        commit_* commit/kill by ID; result_* in-order writeback handshake
module xif_coproc_responder
    import xif_coproc_pkg::*;
#(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]           issue_rs0_i,
    input  logic [31:0]           issue_rs1_i,
    input  logic [1:0]            issue_rs_valid_i,
    output logic                  issue_accept_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic [31:0]           result_data_o,
    output logic                  result_we_o
);
    localparam int PW = $clog2(DEPTH);
    entry_t tbl [DEPTH];
    entry_t tbl_next [DEPTH];
    logic [X_ID_WIDTH-1:0] ids [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic accept, push, pop, full;
    logic [31:0] alu_y;
    entry_state_e commit_state;
    logic unused_bits;
    assign unused_bits = ^issue_instr_i[24:15];
    xif_coproc_alu alu (
        .op(alu_op_e'(issue_instr_i[13:12])),
        .a (issue_rs0_i),
        .b (issue_rs1_i),
        .y (alu_y)
    );
    assign accept = issue_instr_i[6:0] == OPCODE_CUSTOM0 && issue_instr_i[31:25] == FUNCT7_OP &&
                    !issue_instr_i[14] && issue_rs_valid_i == 2'b11;
    assign issue_accept_o = issue_valid_i && accept;
    assign issue_writeback_o = issue_accept_o;
    assign full = count == (PW+1)'(DEPTH);
    assign issue_ready_o = !full && !rst_i;
    assign push = issue_valid_i && issue_ready_o && accept;
    assign result_valid_o = !rst_i && tbl[head].state == COMMITTED;
    assign result_we_o = result_valid_o;
    assign result_id_o = result_valid_o ? ids[head] : '0;
    assign result_rd_o = result_valid_o ? tbl[head].rd : '0;
    assign result_data_o = result_valid_o ? tbl[head].data : '0;
    // killed heads drain silently, one per cycle
    assign pop = (result_valid_o && result_ready_i) || tbl[head].state == KILLED;
    assign commit_state = commit_kill_i ? KILLED : COMMITTED;
    always_comb begin
        tbl_next = tbl;
        for (int i = 0; i < DEPTH; i++)
            if (commit_valid_i && tbl[i].state == ISSUED && ids[i] == commit_id_i)
                tbl_next[i].state = commit_state;
        if (pop) tbl_next[head].state = EMPTY;
        // a same-cycle commit for the incoming ID lands directly on the new entry
        if (push)
            tbl_next[tail] = '{state: (commit_valid_i && commit_id_i == issue_id_i) ? commit_state : ISSUED,
                               rd: issue_instr_i[11:7], data: alu_y};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            tbl <= tbl_next;
            head <= head + PW'(pop);
            tail <= tail + PW'(push);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk_i)
        if (push) ids[tail] <= issue_id_i;
endmodule

// File: tb/tb_xif_coproc_responder.sv
// tb_xif_coproc_responder: directed scenarios plus randomized traffic checked against a queue model
module tb_xif_coproc_responder;
    localparam int XW = 4;
    localparam int D = 4;
    logic clk = 0, rst;
    logic issue_valid, issue_ready, issue_accept, issue_writeback;
    logic [31:0] issue_instr, issue_rs0, issue_rs1;
    logic [XW-1:0] issue_id, commit_id, result_id;
    logic [1:0] issue_rs_valid;
    logic commit_valid, commit_kill;
    logic result_valid, result_ready, result_we;
    logic [4:0] result_rd;
    logic [31:0] result_data;
    int n_tests = 0, n_fail = 0;

    xif_coproc_responder #(.X_ID_WIDTH(XW), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
        .issue_id_i(issue_id), .issue_rs0_i(issue_rs0), .issue_rs1_i(issue_rs1),
        .issue_rs_valid_i(issue_rs_valid), .issue_accept_o(issue_accept), .issue_writeback_o(issue_writeback),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
        .result_rd_o(result_rd), .result_data_o(result_data), .result_we_o(result_we)
    );

    always #5 clk = ~clk;

    // outstanding instructions in issue order; st: 0 waiting for commit, 1 committed, 2 killed
    typedef struct {
        logic [XW-1:0] id;
        logic [4:0]    rd;
        logic [31:0]   data;
        int            st;
    } ment_t;
    ment_t mq[$];

    function automatic logic m_accept(logic [31:0] ins, logic [1:0] rsv);
        return ins[6:0] == 7'h0B && ins[31:25] == 7'd0 && ins[14:12] < 3'd4 && rsv == 2'b11;
    endfunction

    function automatic logic [31:0] m_alu(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            default: return ($signed(a) < $signed(b)) ? a : b;
        endcase
    endfunction

    function automatic logic m_ready();
        return !rst && mq.size() < D;
    endfunction

    function automatic logic m_valid();
        return !rst && mq.size() > 0 && mq[0].st == 1;
    endfunction

    function automatic logic [31:0] mk(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, 10'($urandom), f3, rd, op};
    endfunction

    // advance the model by the current inputs, then clock the DUT
    task automatic tick();
        logic push, pop;
        ment_t e;
        push = issue_valid && m_accept(issue_instr, issue_rs_valid) && m_ready();
        pop = mq.size() > 0 && (mq[0].st == 2 || (mq[0].st == 1 && result_ready));
        if (commit_valid)
            foreach (mq[i]) if (mq[i].st == 0 && mq[i].id == commit_id) mq[i].st = commit_kill ? 2 : 1;
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.id = issue_id;
            e.rd = issue_instr[11:7];
            e.data = m_alu(issue_instr[14:12], issue_rs0, issue_rs1);
            e.st = (commit_valid && commit_id == issue_id) ? (commit_kill ? 2 : 1) : 0;
            mq.push_back(e);
        end
        if (rst) mq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic v, logic [31:0] ins, logic [XW-1:0] id, logic [31:0] a, logic [31:0] b, logic [1:0] rsv);
        issue_valid = v; issue_instr = ins; issue_id = id; issue_rs0 = a; issue_rs1 = b; issue_rs_valid = rsv;
    endtask

    task automatic commit(logic v, logic [XW-1:0] id, logic kill);
        commit_valid = v; commit_id = id; commit_kill = kill;
    endtask

    task automatic idle();
        issue(0, 32'd0, '0, 32'd0, 32'd0, 2'b00);
        commit(0, '0, 0);
    endtask

    task automatic do_reset();
        rst = 1; idle(); result_ready = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; result_ready = 1; commit(0, '0, 0);
        issue(1, mk(0, 0, 5'd1, 7'h0B), 4'd1, 32'd1, 32'd1, 2'b11);
        tick(); tick();
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b exp 0", issue_ready); end
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", result_valid); end
        n_tests++; if (result_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b exp 0", result_we); end
        n_tests++; if ({result_id, result_rd, result_data} !== '0) begin n_fail++;
            $display("FAIL reset_result got id=%0h rd=%0h data=%0h exp 0", result_id, result_rd, result_data); end
        rst = 0; idle(); #1;
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %0b exp 1", issue_ready); end
    endtask

    task automatic test_add_wrap();
        do_reset(); result_ready = 1;
        issue(1, mk(0, 0, 5'd7, 7'h0B), 4'd3, 32'hFFFFFFFF, 32'd2, 2'b11); #1;
        n_tests++; if ({issue_accept, issue_writeback} !== 2'b11) begin n_fail++;
            $display("FAIL add_accept got %b exp 11", {issue_accept, issue_writeback}); end
        tick();
        idle(); commit(1, 4'd3, 0); #1;
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %0b exp 0", result_valid); end
        tick();
        idle(); #1;
        n_tests++; if ({result_valid, result_we, result_id, result_rd, result_data} !== {1'b1, 1'b1, 4'd3, 5'd7, 32'd1}) begin n_fail++;
            $display("FAIL add_result got v=%0b we=%0b id=%0d rd=%0d data=%h exp 1 1 3 7 00000001",
                     result_valid, result_we, result_id, result_rd, result_data); end
        tick(); #1;
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL add_pop got %0b exp 0", result_valid); end
    endtask

    task automatic test_reject();
        do_reset();
        issue(1, mk(0, 0, 5'd5, 7'h33), 4'd4, 32'd1, 32'd2, 2'b11); #1;
        n_tests++; if ({issue_accept, issue_writeback} !== 2'b00) begin n_fail++;
            $display("FAIL reject_accept got %b exp 00", {issue_accept, issue_writeback}); end
        tick();
        idle(); commit(1, 4'd4, 0); result_ready = 1;
        tick(); idle();
        repeat (2) begin
            #1;
            n_tests++; if ({result_valid, issue_ready} !== 2'b01) begin n_fail++;
                $display("FAIL reject_no_result got valid=%0b ready=%0b exp 0 1", result_valid, issue_ready); end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset(); result_ready = 0;
        for (int i = 0; i < D; i++) begin
            issue(1, mk(0, 2, 5'(i + 1), 7'h0B), XW'(i), $urandom, $urandom, 2'b11); #1;
            n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready[%0d] got %0b exp 1", i, issue_ready); end
            tick();
        end
        issue(1, mk(0, 0, 5'd1, 7'h0B), 4'd9, 32'd1, 32'd1, 2'b11); #1;
        n_tests++; if ({issue_ready, issue_accept} !== 2'b01) begin n_fail++;
            $display("FAIL full_ready got ready=%0b accept=%0b exp 0 1", issue_ready, issue_accept); end
        tick();
        idle(); commit(1, 4'd0, 0); #1;
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_commit_ready got %0b exp 0", issue_ready); end
        tick();
        idle(); result_ready = 1; #1;
        n_tests++; if ({result_valid, result_id, issue_ready} !== {1'b1, 4'd0, 1'b0}) begin n_fail++;
            $display("FAIL full_head got valid=%0b id=%0d ready=%0b exp 1 0 0", result_valid, result_id, issue_ready); end
        tick();
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop_ready got %0b exp 1", issue_ready); end
    endtask

    task automatic test_kill();
        logic [31:0] a, b, ins;
        logic [31:0] exp_d[2];
        logic [XW-1:0] got_id[$];
        logic [31:0] got_d[$];
        do_reset(); result_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            a = $urandom; b = $urandom;
            ins = mk(0, 3'($urandom_range(0, 3)), 5'(k), 7'h0B);
            if (k == 1) exp_d[0] = m_alu(ins[14:12], a, b);
            if (k == 3) exp_d[1] = m_alu(ins[14:12], a, b);
            issue(1, ins, XW'(k), a, b, 2'b11);
            tick();
        end
        idle(); commit(1, 4'd2, 1); tick();
        commit(1, 4'd1, 0); tick();
        commit(1, 4'd3, 0); tick();
        idle(); result_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (result_valid) begin got_id.push_back(result_id); got_d.push_back(result_data); end
            tick();
        end
        n_tests++; if (got_id.size() !== 2) begin n_fail++; $display("FAIL kill_count got %0d exp 2", got_id.size()); end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (i >= got_id.size()) begin n_fail++; $display("FAIL kill_result[%0d] got none exp id %0d", i, 2 * i + 1); end
            else if (got_id[i] !== XW'(2 * i + 1) || got_d[i] !== exp_d[i]) begin n_fail++;
                $display("FAIL kill_result[%0d] got id=%0d data=%h exp id=%0d data=%h", i, got_id[i], got_d[i], 2 * i + 1, exp_d[i]); end
        end
    endtask

    task automatic test_same_cycle_min();
        do_reset(); result_ready = 0;
        issue(1, mk(0, 3, 5'd9, 7'h0B), 4'd5, 32'hFFFFFFFC, 32'd7, 2'b11);
        commit(1, 4'd5, 0);
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if ({result_valid, result_id, result_data} !== {1'b1, 4'd5, 32'hFFFFFFFC}) begin n_fail++;
                $display("FAIL min_hold[%0d] got v=%0b id=%0d data=%h exp 1 5 fffffffc", c, result_valid, result_id, result_data); end
            tick();
        end
        result_ready = 1; #1;
        n_tests++; if ({result_valid, result_data} !== {1'b1, 32'hFFFFFFFC}) begin n_fail++;
            $display("FAIL min_ready got v=%0b data=%h exp 1 fffffffc", result_valid, result_data); end
        tick();
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL min_pop got %0b exp 0", result_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset(); result_ready = 0;
        issue(1, mk(0, 0, 5'd1, 7'h0B), 4'd1, $urandom, $urandom, 2'b11); commit(1, 4'd1, 0); tick();
        issue(1, mk(0, 1, 5'd2, 7'h0B), 4'd2, $urandom, $urandom, 2'b11); commit(1, 4'd2, 0); tick();
        idle(); #1;
        n_tests++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending got %0b exp 1", result_valid); end
        rst = 1; tick(); rst = 0; #1;
        n_tests++; if ({result_valid, issue_ready} !== 2'b01) begin n_fail++;
            $display("FAIL rstmid_after got valid=%0b ready=%0b exp 0 1", result_valid, issue_ready); end
        result_ready = 1;
        repeat (3) begin
            tick();
            n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result got %0b exp 1'b0", result_valid); end
        end
    endtask

    task automatic test_random();
        logic [XW-1:0] id, pend[$];
        logic dup, ev, ea;
        logic [6:0] op, f7;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            do begin
                id = XW'($urandom); dup = 0;
                foreach (mq[j]) if (mq[j].id == id) dup = 1;
            end while (dup);
            op = ($urandom_range(0, 99) < 85) ? 7'h0B : 7'h33;
            f7 = ($urandom_range(0, 99) < 90) ? 7'h00 : 7'h20;
            issue($urandom_range(0, 3) != 0, mk(f7, 3'($urandom), 5'($urandom), op), id,
                  ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom,
                  ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11);
            pend.delete();
            foreach (mq[j]) if (mq[j].st == 0) pend.push_back(mq[j].id);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) commit(1, pend[$urandom_range(0, pend.size() - 1)], $urandom_range(0, 9) < 3);
            else if ($urandom_range(0, 4) == 0) commit(1, id, $urandom_range(0, 9) < 3);
            else commit($urandom_range(0, 3) == 0, XW'($urandom), $urandom_range(0, 1));
            result_ready = $urandom_range(0, 2) != 0;
            #1;
            ea = issue_valid && m_accept(issue_instr, issue_rs_valid);
            ev = m_valid();
            n_tests++; if (issue_ready !== m_ready()) begin n_fail++;
                $display("FAIL rand_ready[%0d] got %0b exp %0b", cyc, issue_ready, m_ready()); end
            n_tests++; if ({issue_accept, issue_writeback} !== {ea, ea}) begin n_fail++;
                $display("FAIL rand_accept[%0d] got %b exp %b", cyc, {issue_accept, issue_writeback}, {ea, ea}); end
            n_tests++; if ({result_valid, result_we} !== {ev, ev}) begin n_fail++;
                $display("FAIL rand_valid[%0d] got %b exp %b", cyc, {result_valid, result_we}, {ev, ev}); end
            if (ev) begin
                n_tests++; if ({result_id, result_rd, result_data} !== {mq[0].id, mq[0].rd, mq[0].data}) begin n_fail++;
                    $display("FAIL rand_result[%0d] got id=%0d rd=%0d data=%h exp id=%0d rd=%0d data=%h",
                             cyc, result_id, result_rd, result_data, mq[0].id, mq[0].rd, mq[0].data); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1; result_ready = 0; idle();
        test_reset();
        test_add_wrap();
        test_reject();
        test_full();
        test_kill();
        test_same_cycle_min();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xif_coproc_responder.md
XIF_COPROC_RESPONDER -- requirements
Module: xif_coproc_responder

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, meaning width of the XIF instruction ID.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of outstanding-instruction table entries (power of 2, >=2).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port issue_valid_i, input, 1, the CPU offers an instruction.
REQ-006 SHALL have port issue_ready_o, output, 1, the responder can take an issue handshake.
REQ-007 SHALL have port issue_instr_i, input, 32, the offloaded instruction word.
REQ-008 SHALL have port issue_id_i, input, X_ID_WIDTH, the instruction ID.
REQ-009 SHALL have port issue_rs0_i / issue_rs1_i, input, 32 each, source operands.
REQ-010 SHALL have port issue_rs_valid_i, input, 2, operand valid flags.
REQ-011 SHALL have port issue_accept_o / issue_writeback_o, output, 1 each, issue response.
REQ-012 SHALL have port commit_valid_i, input, 1; commit_id_i, input, X_ID_WIDTH; commit_kill_i, input, 1.
REQ-013 SHALL have port result_valid_o, output, 1; result_ready_i, input, 1.
REQ-014 SHALL have port result_id_o, output, X_ID_WIDTH; result_rd_o, output, 5; result_data_o, output, 32; result_we_o, output, 1.

Function
REQ-015 Accept SHALL hold iff opcode==7'h0B, funct7==0, funct3 in {0..3} and issue_rs_valid_i==2'b11.
REQ-016 Ops SHALL be: funct3 0 rs0+rs1, 1 rs0-rs1, 2 rs0^rs1, 3 signed min; 32-bit, wrap-around modulo 2^32.
REQ-017 issue_accept_o and issue_writeback_o SHALL both equal the accept decode, combinationally, whenever issue_valid_i is high.
REQ-018 issue_ready_o SHALL be !full, with full taken from registered state only (no same-cycle bypass from a result pop).
REQ-019 A non-accepted issue handshake SHALL complete normally and allocate no entry.
REQ-020 An accepted issue handshake SHALL compute the result in the same cycle and write id, rd, data into the tail entry in state ISSUED.
REQ-021 Each entry SHALL be in exactly one state: EMPTY, ISSUED, COMMITTED or KILLED.
REQ-022 A commit whose ID matches an ISSUED entry SHALL move it to COMMITTED (kill=0) or KILLED (kill=1).
REQ-023 A commit whose ID matches no ISSUED entry SHALL be ignored.
REQ-024 A commit with the same ID as an issue handshake in the same cycle SHALL apply to the new entry, writing it directly as COMMITTED or KILLED.
REQ-025 A head entry in state KILLED SHALL be freed silently, one entry per cycle, with no result transaction.
REQ-026 When the head entry is COMMITTED, result_valid_o SHALL be high with result_we_o=1.
REQ-027 The result outputs SHALL hold stable until result_ready_i is sampled high; the head SHALL then pop, giving 1-cycle minimum latency from commit to result_valid_o.
REQ-028 Results SHALL be returned in issue order; head and tail pointers SHALL wrap modulo DEPTH.
REQ-029 An issue and a pop in the same cycle SHALL both take effect.

Reset
REQ-030 While rst_i is high, all entries SHALL be EMPTY and pointers zero.
REQ-031 While rst_i is high, issue_ready_o, result_valid_o, result_we_o, result_id_o, result_rd_o and result_data_o SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL discard all outstanding entries without emitting results.

Structure
REQ-033 A shared package xif_coproc_pkg SHALL hold the opcode/funct constants, the entry-state enum and the table-entry struct.
REQ-034 The arithmetic SHALL live in one combinational sub-module, xif_coproc_alu.

Verification
REQ-035 Scenario: issue add id=3, rs0=0xFFFFFFFF, rs1=2; commit id=3 with kill=0 -> accept=1; result id=3, data=0x00000001 one cycle after commit.
REQ-036 Scenario: issue opcode 0x33 -> accept=0, writeback=0; no entry allocated; no result.
REQ-037 Scenario: DEPTH issues with no commit -> issue_ready_o=0; after one commit and pop, issue_ready_o=1 the following cycle.
REQ-038 Scenario: ids 1,2,3 issued; kill 2; commit 1 and 3 -> results for 1 then 3 only.
REQ-039 Scenario: issue id=5 (min, rs0=-4, rs1=7) with commit id=5 in the same cycle, result_ready_i=0 for 3 cycles -> data=0xFFFFFFFC held stable, pops on the ready cycle.
REQ-040 Scenario: rst_i asserted with 2 committed entries pending -> the next cycle result_valid_o=0 and issue_ready_o=1.
